// File: rtl/uart_pkg.sv
// Shared ASCII constants, FSM encoding and message-length helper for the time sender.
package uart_pkg;

   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic int msg_len(input bit add_crlf);
      return add_crlf ? 10 : 8;
   endfunction

endpackage

// File: rtl/uart_time_sender_if.sv
// Request and FIFO-push signals of the time sender; master is the sender's view.
interface uart_time_sender_if #(
   parameter int HOUR_W = 5
);
   logic              i_send;
   logic [HOUR_W-1:0] i_hour;
   logic [5:0]        i_min;
   logic [5:0]        i_sec;
   logic              i_fifo_full;
   logic              o_push;
   logic [7:0]        o_push_data;
   logic              o_busy;
   logic              o_done;

   modport master (
      input  i_send, i_hour, i_min, i_sec, i_fifo_full,
      output o_push, o_push_data, o_busy, o_done
   );

   modport slave (
      output i_send, i_hour, i_min, i_sec, i_fifo_full,
      input  o_push, o_push_data, o_busy, o_done
   );
endinterface

// File: rtl/bin2bcd_ascii.sv
// Converts a 0..63 binary value to ASCII tens/ones digits via a compare/subtract chain.
// Purely combinational; no handshake.
module bin2bcd_ascii
   import uart_pkg::*;
(
   input  logic [5:0] bin,
   output logic [7:0] tens_ascii,
   output logic [7:0] ones_ascii
);

   logic [2:0] tens;
   logic [5:0] rem;

   // Highest threshold that fits wins; the remainder is always below 10.
   always_comb begin
      tens = 3'd0;
      rem  = bin;
      for (int k = 1; k <= 6; k++) begin
         if (bin >= 6'(10 * k)) begin
            tens = 3'(k);
            rem  = bin - 6'(10 * k);
         end
      end
   end

   assign tens_ascii = ASCII_0 + {5'd0, tens};
   assign ones_ascii = ASCII_0 + {2'd0, rem};

endmodule

// File: rtl/uart_time_sender.sv
// Snapshots hour/min/sec and pushes "HH:MM:SS"[CR LF] one byte per cycle, first byte the cycle after accept.
// A full TX FIFO freezes the byte index (no skip, no repeat); o_done pulses the cycle after the last push.
module uart_time_sender
   import uart_pkg::*;
#(
   parameter int         HOUR_W   = 5,
   parameter logic [7:0] SEP_CHAR = 8'h3A,
   parameter bit         ADD_CRLF = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   uart_time_sender_if.master  bus
);

   localparam int         MSG_LEN  = msg_len(ADD_CRLF);
   localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

   logic [1:0]        state;
   logic [3:0]        idx;
   logic [HOUR_W-1:0] snap_hour;
   logic [5:0]        snap_min;
   logic [5:0]        snap_sec;

   logic [7:0] hour_t, hour_o, min_t, min_o, sec_t, sec_o;
   logic [7:0] cur_byte;
   logic       push;

   bin2bcd_ascii u_hour (
      .bin        (6'(snap_hour)),
      .tens_ascii (hour_t),
      .ones_ascii (hour_o)
   );

   bin2bcd_ascii u_min (
      .bin        (snap_min),
      .tens_ascii (min_t),
      .ones_ascii (min_o)
   );

   bin2bcd_ascii u_sec (
      .bin        (snap_sec),
      .tens_ascii (sec_t),
      .ones_ascii (sec_o)
   );

   always_comb begin
      cur_byte = 8'h00;
      case (idx)
         4'd0:    cur_byte = hour_t;
         4'd1:    cur_byte = hour_o;
         4'd2:    cur_byte = SEP_CHAR;
         4'd3:    cur_byte = min_t;
         4'd4:    cur_byte = min_o;
         4'd5:    cur_byte = SEP_CHAR;
         4'd6:    cur_byte = sec_t;
         4'd7:    cur_byte = sec_o;
         4'd8:    cur_byte = ASCII_CR;
         4'd9:    cur_byte = ASCII_LF;
         default: cur_byte = 8'h00;
      endcase
   end

   assign push            = (state == ST_SEND) && !bus.i_fifo_full;
   assign bus.o_push      = push;
   // Data is forced to zero outside SEND so an idle bus never shows a stale digit.
   assign bus.o_push_data = (state == ST_SEND) ? cur_byte : 8'h00;
   assign bus.o_busy      = (state != ST_IDLE);
   assign bus.o_done      = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         idx       <= 4'd0;
         snap_hour <= '0;
         snap_min  <= 6'd0;
         snap_sec  <= 6'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.i_send) begin
                  snap_hour <= bus.i_hour;
                  snap_min  <= bus.i_min;
                  snap_sec  <= bus.i_sec;
                  idx       <= 4'd0;
                  state     <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (push) begin
                  idx <= idx + 4'd1;
                  if (idx == LAST_IDX) begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_time_sender.sv
// Bench for uart_time_sender: one CR/LF instance and one without, table vectors, corner sequences, random messages.
module tb_uart_time_sender;

   logic       clk;
   logic       rst;
   logic       sel;
   logic       send;
   logic       full;
   logic [4:0] hour;
   logic [5:0] min_v;
   logic [5:0] sec_v;
   logic       push, busy, done;
   logic [7:0] pdat;

   int total = 0;
   int bad   = 0;

   uart_time_sender_if #(.HOUR_W(5)) if_a ();
   uart_time_sender_if #(.HOUR_W(5)) if_b ();

   assign if_a.i_send      = send & ~sel;
   assign if_b.i_send      = send & sel;
   assign if_a.i_hour      = hour;
   assign if_b.i_hour      = hour;
   assign if_a.i_min       = min_v;
   assign if_b.i_min       = min_v;
   assign if_a.i_sec       = sec_v;
   assign if_b.i_sec       = sec_v;
   assign if_a.i_fifo_full = full;
   assign if_b.i_fifo_full = full;

   assign push = sel ? if_b.o_push      : if_a.o_push;
   assign busy = sel ? if_b.o_busy      : if_a.o_busy;
   assign done = sel ? if_b.o_done      : if_a.o_done;
   assign pdat = sel ? if_b.o_push_data : if_a.o_push_data;

   uart_time_sender #(.HOUR_W(5), .SEP_CHAR(8'h3A), .ADD_CRLF(1'b1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a)
   );

   uart_time_sender #(.HOUR_W(5), .SEP_CHAR(8'h3A), .ADD_CRLF(1'b0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          sel;
      int          h;
      int          m;
      int          s;
      logic [31:0] mask;
      bit          disturb;
      logic [79:0] exp;
      int          len;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected text straight from the decimal rules: tens = v/10, ones = v%10.
   function automatic logic [79:0] model_msg(input int h, input int m, input int s, input bit crlf);
      logic [7:0]  b [10];
      logic [79:0] r;
      b[0] = 8'(48 + h / 10);
      b[1] = 8'(48 + h % 10);
      b[2] = 8'h3A;
      b[3] = 8'(48 + m / 10);
      b[4] = 8'(48 + m % 10);
      b[5] = 8'h3A;
      b[6] = 8'(48 + s / 10);
      b[7] = 8'(48 + s % 10);
      b[8] = crlf ? 8'h0D : 8'h00;
      b[9] = crlf ? 8'h0A : 8'h00;
      r = '0;
      for (int i = 0; i < 10; i++) r[79-8*i -: 8] = b[i];
      return r;
   endfunction

   function automatic bit full_at(input logic [31:0] mask, input int c);
      return (c < 32) ? mask[c] : 1'b0;
   endfunction

   // Entered and left at posedge+1 in an IDLE cycle. mask bit c = FIFO full in cycle c after accept.
   task automatic run_msg(input bit s_sel, input int h, input int m, input int s,
                          input logic [31:0] mask, input bit disturb,
                          input logic [79:0] exp, input int len);
      int  idx;
      int  c;
      bit  exp_push;
      sel   = s_sel;
      hour  = 5'(h);
      min_v = 6'(m);
      sec_v = 6'(s);
      full  = 1'b0;
      send  = 1'b1;
      @(negedge clk);
      chk("idle_busy_before_send", int'(busy), 0);
      @(posedge clk);
      #1;
      send = 1'b0;
      idx  = 0;
      c    = 0;
      while (idx < len + 3 && c < 64) begin
         if (disturb && c == 2) begin
            hour  = 5'd1;
            min_v = 6'd2;
            sec_v = 6'd3;
         end
         if (disturb && c == 3) send = 1'b1;
         if (disturb && c == 4) send = 1'b0;
         full = full_at(mask, c);
         @(negedge clk);
         exp_push = (idx < len) && !full;
         chk("push", int'(push), int'(exp_push));
         chk("done", int'(done), int'(idx == len));
         chk("busy", int'(busy), int'(idx <= len));
         if (idx < len) chk("data", int'(pdat), int'(exp[79-8*idx -: 8]));
         if (exp_push || idx >= len) idx++;
         c++;
         @(posedge clk);
         #1;
      end
      full = 1'b0;
   endtask

   logic [79:0] q;

   initial begin
      rst   = 1'b0;
      sel   = 1'b0;
      send  = 1'b0;
      full  = 1'b0;
      hour  = 5'd0;
      min_v = 6'd0;
      sec_v = 6'd0;

      #3;
      chk("rst_push_a", int'(if_a.o_push), 0);
      chk("rst_busy_a", int'(if_a.o_busy), 0);
      chk("rst_done_a", int'(if_a.o_done), 0);
      chk("rst_data_a", int'(if_a.o_push_data), 0);
      chk("rst_push_b", int'(if_b.o_push), 0);
      chk("rst_data_b", int'(if_b.o_push_data), 0);

      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      vecs[0] = '{1'b0, 12, 34, 56, 32'h0,  1'b0, 80'h31323A33343A35360D0A, 10};
      vecs[1] = '{1'b0, 12, 34, 56, 32'h70, 1'b0, 80'h31323A33343A35360D0A, 10};
      vecs[2] = '{1'b0, 12, 34, 56, 32'h0,  1'b1, 80'h31323A33343A35360D0A, 10};
      vecs[3] = '{1'b0,  1,  2,  3, 32'h0,  1'b0, 80'h30313A30323A30330D0A, 10};
      vecs[4] = '{1'b1,  0,  0,  0, 32'h0,  1'b0, 80'h30303A30303A30300000,  8};
      vecs[5] = '{1'b1, 31, 63, 63, 32'h0,  1'b0, 80'h33313A36333A36330000,  8};

      for (int i = 0; i < 6; i++) begin
         run_msg(vecs[i].sel, vecs[i].h, vecs[i].m, vecs[i].s,
                 vecs[i].mask, vecs[i].disturb, vecs[i].exp, vecs[i].len);
      end

      // Reset in the middle of a message: outputs drop at once, nothing trails afterwards.
      sel   = 1'b0;
      hour  = 5'd12;
      min_v = 6'd34;
      sec_v = 6'd56;
      send  = 1'b1;
      @(posedge clk);
      #1;
      send = 1'b0;
      q = model_msg(12, 34, 56, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("pre_rst_push", int'(push), 1);
         chk("pre_rst_data", int'(pdat), int'(q[79-8*c -: 8]));
         if (c < 4) begin
            @(posedge clk);
            #1;
         end
      end
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_push", int'(push), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_done", int'(done), 0);
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("post_rst_push", int'(push), 0);
         chk("post_rst_busy", int'(busy), 0);
      end
      @(posedge clk);
      #1;
      run_msg(1'b0, 12, 34, 56, 32'h0, 1'b0, model_msg(12, 34, 56, 1'b1), 10);

      // i_send held high: exactly one IDLE cycle between o_done and the next first byte.
      sel   = 1'b0;
      hour  = 5'd7;
      min_v = 6'd8;
      sec_v = 6'd9;
      send  = 1'b1;
      q = model_msg(7, 8, 9, 1'b1);
      @(posedge clk);
      #1;
      for (int c = 0; c < 23; c++) begin
         @(negedge clk);
         chk("b2b_push", int'(push), int'((c % 12) < 10));
         chk("b2b_done", int'(done), int'((c % 12) == 10));
         chk("b2b_busy", int'(busy), int'((c % 12) <= 10));
         if ((c % 12) < 10) chk("b2b_data", int'(pdat), int'(q[79-8*(c % 12) -: 8]));
         @(posedge clk);
         #1;
         if (c == 22) send = 1'b0;
      end
      @(negedge clk);
      chk("b2b_end_busy", int'(busy), 0);
      chk("b2b_end_push", int'(push), 0);
      @(posedge clk);
      #1;

      for (int r = 0; r < 20; r++) begin
         bit          rs;
         int          rh, rm, rsec;
         logic [31:0] rmask;
         rs    = 1'($urandom_range(0, 1));
         rh    = int'($urandom_range(0, 31));
         rm    = int'($urandom_range(0, 63));
         rsec  = int'($urandom_range(0, 63));
         rmask = $urandom & $urandom;
         run_msg(rs, rh, rm, rsec, rmask, 1'b0, model_msg(rh, rm, rsec, !rs), rs ? 8 : 10);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_time_sender.md
Name: uart_time_sender

Overview:
- Formats a snapshot of the clock time (hour, minute, second) as ASCII text "HH:MM:SS" with an optional CR LF.
- Streams the bytes, one per cycle, into the TX-side push interface of the UART FIFO controller (its i_push / i_push_data inputs).
- Sits directly upstream of the UART FIFO controller. Honours TX FIFO backpressure through a full input.

Parameters:
- HOUR_W, 5, width of the hour input (max value 31).
- SEP_CHAR, 8'h3A, separator byte between fields (':').
- ADD_CRLF, 1, 1 appends 8'h0D 8'h0A (message length 10); 0 omits them (length 8).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately while low.
- i_send  input  1  request to send one message; sampled only in IDLE.
- i_hour  input  HOUR_W  hour value, binary.
- i_min  input  6  minute value, binary.
- i_sec  input  6  second value, binary.
- i_fifo_full  input  1  TX FIFO full; no push occurs while high.
- o_push  output  1  byte-valid strobe to the FIFO push input.
- o_push_data  output  8  ASCII byte being pushed.
- o_busy  output  1  high from message accept until o_done.
- o_done  output  1  one-cycle pulse after the last byte is pushed.

Behaviour:
- Reset (rst low): state = IDLE, byte index = 0, snapshot registers = 0, o_done = 0. Combinationally this gives o_push = 0, o_busy = 0, o_push_data = 8'h00.
- Reset is asynchronous and overrides everything, including mid-message. A partially pushed message is abandoned, and no further bytes follow after reset is released.
- States: IDLE, SEND, DONE.
- IDLE: when i_send = 1 at a clock edge:
  - latch i_hour, i_min, i_sec into the snapshot;
  - clear the index to 0;
  - go to SEND.
- i_send is level-sampled. If it is held high, a new message starts on the first IDLE cycle after DONE.
- SEND:
  - o_push = ~i_fifo_full (combinational).
  - o_push_data = byte[index] from the snapshot (combinational mux).
  - Each edge with o_push = 1 increments the index.
  - When the index equals MSG_LEN-1 and o_push = 1, go to DONE.
- DONE: o_done = 1 for exactly one cycle, o_push = 0, then return to IDLE.
- o_busy = 1 in SEND and DONE.
- i_send in SEND or DONE is ignored; no queueing.
- Byte order (MSG_LEN = 8 or 10):
  - H tens, H ones, SEP, M tens, M ones, SEP, S tens, S ones;
  - then [0D, 0A] if ADD_CRLF = 1.
- Digit conversion: tens = v/10 and ones = v%10 of the snapshot value, each output as 8'h30 + digit.
  - No clamping of out-of-range values: hour up to 31, min/sec up to 63 are printed as-is (e.g. 63 → "63").
- Input changes during SEND have no effect (snapshot only).
- Latency:
  - first byte pushed in the cycle after i_send is accepted, if not full;
  - with no backpressure, bytes go out on MSG_LEN consecutive cycles;
  - o_done follows in the next cycle.
- Backpressure: while i_fifo_full = 1, the index and o_push_data hold and o_push = 0. Stall length is unbounded, and no byte is skipped or duplicated.
- i_fifo_full rising in the same cycle as the last byte blocks that push; DONE waits.

Decomposition:
- Shared package (uart_pkg):
  - ASCII_0 = 8'h30, ASCII_CR = 8'h0D, ASCII_LF = 8'h0A;
  - state encoding localparams for IDLE, SEND, DONE.
- One natural sub-module: bin2bcd_ascii. It converts a 6-bit binary value to two ASCII digit bytes (tens, ones) using a compare/subtract chain, with no divider. The hour input is zero-extended to 6 bits, and the sub-module is instantiated three times on the snapshot registers.

Test Plan:
- Snapshot 12:34:56, ADD_CRLF = 1, full held low, one-cycle i_send → bytes 31 32 3A 33 34 3A 35 36 0D 0A on 10 consecutive cycles starting 1 cycle after accept; o_done pulses 1 cycle after byte 0A; o_busy low afterwards.
- Same message with i_fifo_full high for 3 cycles after the 4th byte → o_push low for those 3 cycles; bytes 34 3A 35 36 0D 0A then continue in order; exactly 10 pushes total.
- i_send pulsed again during SEND, and inputs changed to 01:02:03 during SEND → the first message is unaffected and no second message is sent; a later i_send in IDLE sends 30 31 3A 30 32 3A 30 33 0D 0A.
- Boundaries with ADD_CRLF = 0: 00:00:00 → 30 30 3A 30 30 3A 30 30, then done; 31:63:63 → 33 31 3A 36 33 3A 36 33, then done.
- rst driven low after the 5th byte, released, then i_send → o_push, o_busy, o_done drop immediately while rst is low; no residual bytes; the new message starts from H tens.
- i_send held high continuously → back-to-back messages with exactly one IDLE cycle between o_done and the next first byte.
